// File: rtl/demux_stream_pkg.sv
// Shared types and constants for the registered stream demultiplexer.
package demux_stream_pkg;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_e;

  localparam int                    DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/demux_stream_slot.sv
// One-entry holding buffer for a single router output (EMPTY/FULL).
module demux_stream_slot
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  chan_state_e      state_p1, state_nxt;
  logic [WIDTH-1:0] held_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p1 <= CH_EMPTY;
    else        state_p1 <= state_nxt;
  end

  // Data is never read while EMPTY, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) held_p1 <= data;
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      CH_EMPTY: if (push)           state_nxt = CH_FULL;
      CH_FULL:  if (!push && ready) state_nxt = CH_EMPTY;
      default:                      state_nxt = CH_EMPTY;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    q     = '0;
    if (state_p1 == CH_FULL) begin
      valid = 1'b1;
      q     = held_p1;
    end
  end

endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-CHANNELS stream router with per-channel holding buffers.
// Optional broadcast transfers are enabled with macro DEMUX_STREAM_BCAST_EN.
module demux_stream_router
  import demux_stream_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
`ifdef DEMUX_STREAM_BCAST_EN
  input  logic                      in_bcast,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic                oob;
  logic                sel_full;
  logic                sel_rdy;
  logic                uni_ok;
  logic                accept;
  logic                drop_inc;
  logic [CHANNELS-1:0] uni_hit;
  logic [CHANNELS-1:0] push;

  // Selects beyond the last channel exist only for non-power-of-two counts.
  if (CHANNELS < (1 << SEL_W)) begin : g_oob
    assign oob = (in_sel >= SEL_W'(CHANNELS));
  end else begin : g_no_oob
    assign oob = 1'b0;
  end

  always_comb begin
    sel_full = 1'b0;
    sel_rdy  = 1'b0;
    uni_hit  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_full   = out_valid[k];
        sel_rdy    = out_ready[k];
        uni_hit[k] = 1'b1;
      end
    end
  end

  assign uni_ok = oob | ~sel_full | sel_rdy;
  assign accept = in_valid & in_ready;

`ifdef DEMUX_STREAM_BCAST_EN
  logic all_ok;

  // A broadcast waits until every channel can take a word this cycle.
  assign all_ok   = &(~out_valid | out_ready);
  assign in_ready = rst_n & enable & (in_bcast ? all_ok : uni_ok);
  assign push     = {CHANNELS{accept}} & (in_bcast ? {CHANNELS{1'b1}} : uni_hit);
  assign drop_inc = accept & oob & ~in_bcast;
`else
  assign in_ready = rst_n & enable & uni_ok;
  assign push     = {CHANNELS{accept}} & uni_hit;
  assign drop_inc = accept & oob;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        drop_cnt <= '0;
    else if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
  end

  // Output stage: one registered buffer per channel.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    demux_stream_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push[k]),
      .data (in_data),
      .ready(out_ready[k]),
      .valid(out_valid[k]),
      .q    (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule
